// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared 640x480@60 timing constants, RGB332 field widths and
//               the capture-side lock FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Horizontal timing in pixel ticks
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // Vertical timing in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // RGB 3:3:2 pixel fields
  localparam int RGB_R_W = 3;
  localparam int RGB_G_W = 3;
  localparam int RGB_B_W = 2;
  localparam int RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

  // Capture lock state machine
  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } cap_state_e;

  // Decimation shift for a scale select; code 3 behaves like 1/4
  function automatic logic [1:0] scale_shift(input logic [1:0] sel);
    return (sel == 2'd3) ? 2'd2 : sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_edge
// Description : Pixel-enable qualified input registers for HS/VS/RGB with
//               falling-edge detection of the active-low syncs.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_edge
  import vga_pkg::*;
(
  input  logic             ck,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             smp_stb,
  output logic             hs_fall,
  output logic             vs_fall,
  output logic [RGB_W-1:0] rgb
);

  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             hs_prev_q, hs_prev_d;
  logic             vs_prev_q, vs_prev_d;
  logic             stb_q, stb_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  // Capture a new sample (and shift the old one to "previous") on pix_en
  always_comb begin
    hs_d      = hs_q;
    vs_d      = vs_q;
    hs_prev_d = hs_prev_q;
    vs_prev_d = vs_prev_q;
    rgb_d     = rgb_q;
    stb_d     = pix_en;
    if (pix_en) begin
      hs_prev_d = hs_q;
      vs_prev_d = vs_q;
      hs_d      = hs_in;
      vs_d      = vs_in;
      rgb_d     = rgb_in;
    end
  end

  // Input registers; syncs idle high out of reset so no false edge is seen
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      rgb_q     <= '0;
      stb_q     <= 1'b0;
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      rgb_q     <= rgb_d;
      stb_q     <= stb_d;
    end
  end

  // smp_stb marks the single ck in which a freshly captured sample is processed
  assign smp_stb = stb_q;
  assign hs_fall = stb_q & hs_prev_q & ~hs_q;
  assign vs_fall = stb_q & vs_prev_q & ~vs_q;
  assign rgb     = rgb_q;

endmodule
`default_nettype wire

// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
// Module      : vga_capture
// Description : VGA input capture: timing lock detection, 1/2/4 decimation
//               of the active picture and frame-buffer pixel write stream.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_capture
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int H_START  = VGA_H_SYNC + VGA_H_BP,
  parameter int V_START  = VGA_V_SYNC + VGA_V_BP,
  parameter int H_TOTAL  = VGA_H_TOTAL,
  parameter int V_TOTAL  = VGA_V_TOTAL
) (
  input  logic               ck,
  input  logic               rst_n,
  input  logic               pix_en,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic [RGB_R_W-1:0] red_in,
  input  logic [RGB_G_W-1:0] green_in,
  input  logic [RGB_B_W-1:0] blue_in,
  input  logic [1:0]         scale,
  output logic               pix_valid,
  output logic [RGB_W-1:0]   pix_data,
  output logic [9:0]         pix_x,
  output logic [8:0]         pix_y,
  output logic               frame_start,
  output logic               locked,
  output logic [10:0]        h_total_meas
);

  localparam logic [10:0] c_h_start = 11'(H_START);
  localparam logic [10:0] c_h_end   = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] c_h_total = 11'(H_TOTAL);
  localparam logic [9:0]  c_v_start = 10'(V_START);
  localparam logic [9:0]  c_v_end   = 10'(V_START + V_ACTIVE);
  localparam logic [9:0]  c_v_total = 10'(V_TOTAL);

  logic             smp_stb, hs_fall, vs_fall;
  logic [RGB_W-1:0] rgb;

  vga_sync_edge u_sync_edge (
    .ck      (ck),
    .rst_n   (rst_n),
    .pix_en  (pix_en),
    .hs_in   (hs_in),
    .vs_in   (vs_in),
    .rgb_in  ({red_in, green_in, blue_in}),
    .smp_stb (smp_stb),
    .hs_fall (hs_fall),
    .vs_fall (vs_fall),
    .rgb     (rgb)
  );

  logic [10:0]      hcnt_q, hcnt_d, hcnt_inc;
  logic [9:0]       vcnt_q, vcnt_d, vcnt_inc;
  logic [10:0]      h_total_meas_q, h_total_meas_d;
  logic [1:0]       scale_q, scale_d;
  logic [9:0]       hact;
  logic [8:0]       vact;
  logic [1:0]       dec_mask;
  logic             in_win, emit, h_sat, v_sat, line_bad, frame_ok;
  logic             pix_valid_q, pix_valid_d;
  logic [RGB_W-1:0] pix_data_q, pix_data_d;
  logic [9:0]       pix_x_q, pix_x_d;
  logic [8:0]       pix_y_q, pix_y_d;
  logic             frame_start_q, frame_start_d;
  cap_state_e       state_q;
  logic [1:0]       match_q;
  logic             line_err_q;
  logic             locked_q;

  // Position counters, line measurement and decimation decision for the current sample
  always_comb begin
    hcnt_inc       = (hcnt_q == 11'h7ff) ? hcnt_q : hcnt_q + 11'd1;
    vcnt_inc       = (vcnt_q == 10'h3ff) ? vcnt_q : vcnt_q + 10'd1;
    hcnt_d         = hcnt_q;
    vcnt_d         = vcnt_q;
    h_total_meas_d = h_total_meas_q;
    scale_d        = scale_q;
    if (smp_stb) begin
      hcnt_d = hs_fall ? 11'd0 : hcnt_inc;
      if (vs_fall)      vcnt_d = 10'd0;
      else if (hs_fall) vcnt_d = vcnt_inc;
      // hcnt_inc is the tick count of the line that just ended
      if (hs_fall) h_total_meas_d = hcnt_inc;
      if (vs_fall) scale_d = scale_shift(scale);
    end
    h_sat    = smp_stb & (hcnt_d == 11'h7ff);
    v_sat    = smp_stb & (vcnt_d == 10'h3ff);
    line_bad = hs_fall & (hcnt_inc != c_h_total);
    frame_ok = (vcnt_inc == c_v_total);

    in_win   = (hcnt_d >= c_h_start) && (hcnt_d < c_h_end) &&
               (vcnt_d >= c_v_start) && (vcnt_d < c_v_end);
    hact     = 10'(hcnt_d - c_h_start);
    vact     = 9'(vcnt_d - c_v_start);
    dec_mask = (scale_q == 2'd0) ? 2'b00 : (scale_q == 2'd1) ? 2'b01 : 2'b11;
    emit     = smp_stb & locked_q & in_win &
               ((hact[1:0] & dec_mask) == 2'b00) &
               ((vact[1:0] & dec_mask) == 2'b00);

    pix_valid_d   = emit;
    frame_start_d = emit & (hact == 10'd0) & (vact == 9'd0);
    pix_data_d    = pix_data_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    if (emit) begin
      pix_data_d = rgb;
      pix_x_d    = hact >> scale_q;
      pix_y_d    = vact >> scale_q;
    end
  end

  // Counter, measurement and output registers
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q         <= '0;
      vcnt_q         <= '0;
      h_total_meas_q <= '0;
      scale_q        <= '0;
      pix_valid_q    <= 1'b0;
      pix_data_q     <= '0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      frame_start_q  <= 1'b0;
    end else begin
      hcnt_q         <= hcnt_d;
      vcnt_q         <= vcnt_d;
      h_total_meas_q <= h_total_meas_d;
      scale_q        <= scale_d;
      pix_valid_q    <= pix_valid_d;
      pix_data_q     <= pix_data_d;
      pix_x_q        <= pix_x_d;
      pix_y_q        <= pix_y_d;
      frame_start_q  <= frame_start_d;
    end
  end

  // Lock FSM: two consecutive clean frames in MEASURE give lock; lost sync restarts the search
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SEARCH;
      match_q    <= 2'd0;
      line_err_q <= 1'b0;
      locked_q   <= 1'b0;
    end else if (h_sat || v_sat) begin
      state_q    <= ST_SEARCH;
      match_q    <= 2'd0;
      line_err_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (vs_fall) begin
            state_q    <= ST_MEASURE;
            match_q    <= 2'd0;
            line_err_q <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if (vs_fall) begin
            // The line ending on this edge counts towards the frame being judged
            line_err_q <= 1'b0;
            if (frame_ok && !line_err_q && !line_bad) begin
              if (match_q == 2'd1) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
                match_q  <= 2'd2;
              end else begin
                match_q <= match_q + 2'd1;
              end
            end else begin
              match_q <= 2'd0;
            end
          end else if (line_bad) begin
            match_q    <= 2'd0;
            line_err_q <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (line_bad || (vs_fall && !frame_ok)) begin
            state_q    <= ST_MEASURE;
            locked_q   <= 1'b0;
            match_q    <= 2'd0;
            // A bad line mid-frame taints the rest of that frame
            line_err_q <= line_bad & ~vs_fall;
          end
        end
        default: begin
          state_q    <= ST_SEARCH;
          match_q    <= 2'd0;
          line_err_q <= 1'b0;
          locked_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pix_valid    = pix_valid_q;
  assign pix_data     = pix_data_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign h_total_meas = h_total_meas_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_capture
// Description : Self-checking bench for vga_capture using a reduced raster
//               (26x13 total, 16x8 active) and an expected-pixel queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_capture;

  localparam int H_ACT  = 16;
  localparam int H_SYNC = 2;
  localparam int H_ST   = 6;
  localparam int H_TOT  = 26;
  localparam int V_ACT  = 8;
  localparam int V_SYNC = 2;
  localparam int V_ST   = 3;
  localparam int V_TOT  = 13;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       hs_in = 1'b1;
  logic       vs_in = 1'b1;
  logic [2:0] red_in = '0;
  logic [2:0] green_in = '0;
  logic [1:0] blue_in = '0;
  logic [1:0] scale = 2'd0;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic       frame_start;
  logic       locked;
  logic [10:0] h_total_meas;

  int n_checks = 0;
  int n_err    = 0;
  int n_valid  = 0;
  int n_fs     = 0;
  int frame_no = 0;
  logic [27:0] exp_q[$];

  vga_capture #(
    .H_ACTIVE (H_ACT),
    .V_ACTIVE (V_ACT),
    .H_START  (H_ST),
    .V_START  (V_ST),
    .H_TOTAL  (H_TOT),
    .V_TOTAL  (V_TOT)
  ) dut (
    .ck           (ck),
    .rst_n        (rst_n),
    .pix_en       (pix_en),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .red_in       (red_in),
    .green_in     (green_in),
    .blue_in      (blue_in),
    .scale        (scale),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .frame_start  (frame_start),
    .locked       (locked),
    .h_total_meas (h_total_meas)
  );

  always #5 ck = ~ck;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: every strobe is matched against the oldest expected pixel
  always @(negedge ck) begin
    if (rst_n) begin
      if (frame_start && !pix_valid)
        check_val("fs_without_valid", 32'(frame_start), 32'd0);
      if (pix_valid) begin
        n_valid++;
        if (frame_start) n_fs++;
        if (exp_q.size() == 0) begin
          check_val("spurious_valid", 32'(pix_valid), 32'd0);
        end else begin
          check_val("pix", 32'({frame_start, pix_y, pix_x, pix_data}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // One pixel tick: inputs valid with pix_en for one ck, then one idle ck
  task automatic tick(input logic h, input logic v, input logic [7:0] d);
    @(negedge ck);
    pix_en = 1'b1;
    hs_in  = h;
    vs_in  = v;
    {red_in, green_in, blue_in} = d;
    @(negedge ck);
    pix_en = 1'b0;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_valid"}, 32'(pix_valid), 32'd0);
    check_val({pfx, "_data"},  32'(pix_data), 32'd0);
    check_val({pfx, "_x"},     32'(pix_x), 32'd0);
    check_val({pfx, "_y"},     32'(pix_y), 32'd0);
    check_val({pfx, "_fs"},    32'(frame_start), 32'd0);
    check_val({pfx, "_locked"}, 32'(locked), 32'd0);
    check_val({pfx, "_meas"},  32'(h_total_meas), 32'd0);
  endtask

  // One source frame. exp_emit: bench expects the DUT locked for this frame.
  // stretch_l >= 0 lengthens that line by one tick; chg_l changes scale at that line;
  // rst_l pulses rst_n inside that active line.
  task automatic run_frame(input bit exp_emit, input int sc, input int stretch_l,
                           input int chg_l, input logic [1:0] chg_v, input int rst_l);
    int s, len, pushed, pushed_fs, base_v, base_fs;
    bit emit_on;
    logic h, v, fs;
    logic [7:0] d;
    s = 1 << sc;
    emit_on = exp_emit;
    pushed = 0; pushed_fs = 0;
    base_v = n_valid; base_fs = n_fs;
    for (int l = 0; l < V_TOT; l++) begin
      if (l == chg_l) scale = chg_v;
      if (stretch_l >= 0 && l == stretch_l + 1) emit_on = 1'b0;
      len = (l == stretch_l) ? H_TOT + 1 : H_TOT;
      for (int p = 0; p < len; p++) begin
        h = (p >= H_SYNC);
        v = (l >= V_SYNC);
        d = 8'(frame_no * 37 + l * 11 + p * 3);
        if (emit_on && p >= H_ST && p < H_ST + H_ACT && l >= V_ST && l < V_ST + V_ACT &&
            ((p - H_ST) % s == 0) && ((l - V_ST) % s == 0)) begin
          fs = (p == H_ST) && (l == V_ST);
          exp_q.push_back({fs, 9'((l - V_ST) / s), 10'((p - H_ST) / s), d});
          pushed++;
          if (fs) pushed_fs++;
        end
        tick(h, v, d);
        if (stretch_l >= 0 && l == stretch_l + 1 && p == 0) begin
          @(posedge ck); #1;
          check_val("stretch_lock_drop", 32'(locked), 32'd0);
          check_val("stretch_meas", 32'(h_total_meas), 32'(H_TOT + 1));
        end
        if (l == rst_l && p == H_ST + 4) begin
          #1 rst_n = 1'b0;
          #1 check_outputs_zero("midrst");
          exp_q.delete();
          repeat (3) @(negedge ck);
          rst_n = 1'b1;
          emit_on = 1'b0;
          pushed = 0; pushed_fs = 0;
          base_v = n_valid; base_fs = n_fs;
        end
      end
    end
    check_val($sformatf("count_f%0d", frame_no), 32'(n_valid - base_v), 32'(pushed));
    check_val($sformatf("fs_f%0d", frame_no), 32'(n_fs - base_fs), 32'(pushed_fs));
    check_val($sformatf("left_f%0d", frame_no), 32'(exp_q.size()), 32'd0);
    frame_no++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge ck);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (3) tick(1'b1, 1'b1, 8'h00);

    // Acquisition: frames 0 and 1 are measured, frame 2 is the first emitted
    run_frame(1'b0, 0, -1, -1, 2'd0, -1);
    run_frame(1'b0, 0, -1, -1, 2'd0, -1);
    check_val("prelock", 32'(locked), 32'd0);
    run_frame(1'b1, 0, -1, -1, 2'd0, -1);
    check_val("locked_f2", 32'(locked), 32'd1);
    check_val("meas_clean", 32'(h_total_meas), 32'(H_TOT));

    // Half-size frame
    scale = 2'd1;
    run_frame(1'b1, 1, -1, -1, 2'd0, -1);

    // Mid-frame change to quarter size only takes effect on the next frame
    scale = 2'd0;
    run_frame(1'b1, 0, -1, 5, 2'd2, -1);
    run_frame(1'b1, 2, -1, -1, 2'd0, -1);

    // Scale code 3 acts as quarter size
    scale = 2'd3;
    run_frame(1'b1, 2, -1, -1, 2'd0, -1);

    // Line 5 stretched by one tick: lock lost, frame tainted, two clean frames re-lock
    run_frame(1'b1, 2, 5, -1, 2'd0, -1);
    scale = 2'd0;
    run_frame(1'b0, 0, -1, -1, 2'd0, -1);
    run_frame(1'b0, 0, -1, -1, 2'd0, -1);
    run_frame(1'b1, 0, -1, -1, 2'd0, -1);

    // HS lost for more than 2047 ticks
    for (int i = 0; i < 2100; i++) tick(1'b1, 1'b1, 8'h5a);
    @(posedge ck); #1;
    check_val("hs_lost_unlock", 32'(locked), 32'd0);
    run_frame(1'b0, 0, -1, -1, 2'd0, -1);
    run_frame(1'b0, 0, -1, -1, 2'd0, -1);

    // Locked frame interrupted by a reset in an active line, then re-acquired
    run_frame(1'b1, 0, -1, -1, 2'd0, 5);
    check_val("post_rst_unlocked", 32'(locked), 32'd0);
    run_frame(1'b0, 0, -1, -1, 2'd0, -1);
    run_frame(1'b0, 0, -1, -1, 2'd0, -1);
    run_frame(1'b1, 0, -1, -1, 2'd0, -1);
    check_val("relock_after_rst", 32'(locked), 32'd1);

    repeat (4) @(negedge ck);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
